// File: rtl/dm_bus_arb_pkg.sv
// Shared types for the debug-module bus arbiter: FSM states and owner-index sizing.
// Pure declarations, no logic; imported by the arbiter and its round-robin picker.
package dm_bus_arb_pkg;

    localparam int MAX_REQ = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCKED   = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

    // Owner index width, clog2(NR_REQ) but never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dm_rr_picker.sv
// Round-robin picker: first requesting index strictly after last_owner, wrapping.
// Purely combinational (zero latency); no backpressure, the caller decides when to use the pick.
// Ties are impossible: exactly one index is nearest after last_owner.
module dm_rr_picker
    import dm_bus_arb_pkg::*;
#(
    parameter int NR_REQ = 2,
    localparam int IW = idx_w(NR_REQ)
) (
    input  logic [NR_REQ-1:0] req,
    input  logic [IW-1:0]     last_owner,
    output logic [IW-1:0]     winner,
    output logic              valid
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        // Walk from farthest to nearest so the nearest requester is written last.
        for (int i = NR_REQ; i >= 1; i--) begin
            idx = (int'(last_owner) + i) % NR_REQ;
            if (req[idx]) begin
                winner = IW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter of NR_REQ requesters onto one downstream bus, one transaction outstanding.
// Zero-cycle arbitration in IDLE; grant and response are forwarded combinationally the same cycle.
// Holds the locked request until mst_gnt_i; DM_BUS_ARB_TIMEOUT_EN adds a response timeout with stale-response absorption.
module dm_bus_arbiter
    import dm_bus_arb_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int NR_REQ         = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NR_REQ-1:0]               req_i,
    input  logic [NR_REQ-1:0][XLEN-1:0]     add_i,
    input  logic [NR_REQ-1:0][XLEN-1:0]     wdata_i,
    input  logic [NR_REQ-1:0]               we_i,
    input  logic [NR_REQ-1:0][XLEN/8-1:0]   be_i,
    output logic [NR_REQ-1:0]               gnt_o,
    output logic [NR_REQ-1:0]               r_valid_o,
    output logic [NR_REQ-1:0]               r_err_o,
    output logic [NR_REQ-1:0][XLEN-1:0]     r_rdata_o,
    output logic                            mst_req_o,
    output logic                            mst_we_o,
    output logic [XLEN-1:0]                 mst_add_o,
    output logic [XLEN-1:0]                 mst_wdata_o,
    output logic [XLEN/8-1:0]               mst_be_o,
    input  logic                            mst_gnt_i,
    input  logic                            mst_r_valid_i,
    input  logic [XLEN-1:0]                 mst_rdata_i
);

    localparam int IW = idx_w(NR_REQ);

    if (NR_REQ < 2 || NR_REQ > MAX_REQ || TIMEOUT_CYCLES < 2) begin : g_param_chk
        $error("dm_bus_arbiter: NR_REQ must be 2..4 and TIMEOUT_CYCLES at least 2");
    end

    arb_state_e    state;
    logic [IW-1:0] owner, last_owner, winner, sel;
    logic          win_vld, blocked, act;
    logic          stale_hit, to_hit, rsp_real, rsp_to, rsp;

    dm_rr_picker #(.NR_REQ(NR_REQ)) u_picker (
        .req        (req_i),
        .last_owner (last_owner),
        .winner     (winner),
        .valid      (win_vld)
    );

`ifdef DM_BUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic [1:0]    stale_cnt;

    assign to_hit    = (state == WAIT_RSP) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign stale_hit = mst_r_valid_i && (stale_cnt != 2'd0);
    assign blocked   = (stale_cnt == 2'd3);

    // A late response belongs to the oldest timed-out transaction, so it is eaten wherever it lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt    <= '0;
            stale_cnt <= 2'd0;
        end else begin
            to_cnt <= (state == WAIT_RSP && !rsp) ? to_cnt + 1'b1 : '0;
            case ({rsp_to, stale_hit})
                2'b10:   if (stale_cnt != 2'd3) stale_cnt <= stale_cnt + 2'd1;
                2'b01:   stale_cnt <= stale_cnt - 2'd1;
                default: stale_cnt <= stale_cnt;
            endcase
        end
    end
`else
    assign to_hit    = 1'b0;
    assign stale_hit = 1'b0;
    assign blocked   = 1'b0;
`endif

    assign sel      = (state == IDLE) ? winner : owner;
    assign act      = !rst && (((state == IDLE) && win_vld && !blocked) ||
                               ((state == LOCKED) && req_i[owner]));
    assign rsp_real = (state == WAIT_RSP) && mst_r_valid_i && !stale_hit;
    assign rsp_to   = to_hit && !rsp_real;
    assign rsp      = !rst && (rsp_real || rsp_to);

    always_comb begin
        gnt_o       = '0;
        r_valid_o   = '0;
        r_err_o     = '0;
        r_rdata_o   = '0;
        mst_req_o   = 1'b0;
        mst_we_o    = 1'b0;
        mst_add_o   = '0;
        mst_wdata_o = '0;
        mst_be_o    = '0;
        if (act) begin
            mst_req_o   = 1'b1;
            mst_we_o    = we_i[sel];
            mst_add_o   = add_i[sel];
            mst_wdata_o = wdata_i[sel];
            mst_be_o    = be_i[sel];
            gnt_o[sel]  = mst_gnt_i;
        end
        if (rsp) begin
            r_valid_o[owner] = 1'b1;
            r_err_o[owner]   = rsp_to;
            r_rdata_o[owner] = rsp_real ? mst_rdata_i : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(NR_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (act) begin
                        owner <= winner;
                        state <= mst_gnt_i ? WAIT_RSP : LOCKED;
                    end
                end
                LOCKED: begin
                    if (!req_i[owner])  state <= IDLE;
                    else if (mst_gnt_i) state <= WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (rsp) begin
                        last_owner <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed bench for dm_bus_arbiter (NR_REQ=2, XLEN=64, TIMEOUT_CYCLES=16).
// Expected grants/responses are queued by the stimulus and popped by a negedge monitor.
module tb_dm_bus_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_i, we_i;
    logic [1:0][63:0]  add_i, wdata_i;
    logic [1:0][7:0]   be_i;
    logic [1:0]        gnt_o, r_valid_o, r_err_o;
    logic [1:0][63:0]  r_rdata_o;
    logic              mst_req_o, mst_we_o;
    logic [63:0]       mst_add_o, mst_wdata_o;
    logic [7:0]        mst_be_o;
    logic              mst_gnt_i, mst_r_valid_i;
    logic [63:0]       mst_rdata_i;

    typedef struct {
        int          idx;
        logic [63:0] add;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  be;
    } gnt_exp_t;

    typedef struct {
        int          idx;
        logic [63:0] rdata;
        logic        err;
    } rsp_exp_t;

    gnt_exp_t gq[$];
    rsp_exp_t rq[$];
    int checks = 0;
    int errors = 0;

    dm_bus_arbiter #(.XLEN(64), .NR_REQ(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .add_i(add_i), .wdata_i(wdata_i),
        .we_i(we_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
        .r_err_o(r_err_o), .r_rdata_o(r_rdata_o), .mst_req_o(mst_req_o),
        .mst_we_o(mst_we_o), .mst_add_o(mst_add_o), .mst_wdata_o(mst_wdata_o),
        .mst_be_o(mst_be_o), .mst_gnt_i(mst_gnt_i), .mst_r_valid_i(mst_r_valid_i),
        .mst_rdata_i(mst_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic w,
                           input logic [63:0] d, input logic [7:0] b);
        add_i[i]   = a;
        we_i[i]    = w;
        wdata_i[i] = d;
        be_i[i]    = b;
        req_i[i]   = 1'b1;
    endtask

    task automatic exp_gnt(input int i);
        gnt_exp_t g;
        g.idx   = i;
        g.add   = add_i[i];
        g.we    = we_i[i];
        g.wdata = wdata_i[i];
        g.be    = be_i[i];
        gq.push_back(g);
    endtask

    task automatic exp_rsp(input int i, input logic [63:0] d, input logic e);
        rsp_exp_t r;
        r.idx   = i;
        r.rdata = d;
        r.err   = e;
        rq.push_back(r);
    endtask

    // Monitor: every grant or response the DUT presents must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt_o != 2'b00) begin
                if (gq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got gnt_o=%b, expected none", gnt_o);
                end else begin
                    gnt_exp_t g;
                    logic [1:0] ev;
                    g = gq.pop_front();
                    ev = '0;
                    ev[g.idx] = 1'b1;
                    chk("gnt_vec", gnt_o, ev);
                    chk("mst_req", mst_req_o, 1'b1);
                    chk("mst_add", mst_add_o, g.add);
                    chk("mst_we", mst_we_o, g.we);
                    chk("mst_wdata", mst_wdata_o, g.wdata);
                    chk("mst_be", mst_be_o, g.be);
                end
            end
            if (r_valid_o != 2'b00) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got r_valid_o=%b, expected none", r_valid_o);
                end else begin
                    rsp_exp_t r;
                    logic [1:0] ev, ee;
                    logic [1:0][63:0] ed;
                    r = rq.pop_front();
                    ev = '0;
                    ee = '0;
                    ed = '0;
                    ev[r.idx] = 1'b1;
                    ee[r.idx] = r.err;
                    ed[r.idx] = r.rdata;
                    chk("r_valid_vec", r_valid_o, ev);
                    chk("r_err_vec", r_err_o, ee);
                    chk("r_rdata_vec", r_rdata_o, ed);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_i = '0; we_i = '0; add_i = '0; wdata_i = '0; be_i = '0;
        mst_gnt_i = 1'b0; mst_r_valid_i = 1'b0; mst_rdata_i = '0;
        cyc();
        // Reset must hold every output low even with live inputs.
        req_i = 2'b01; mst_gnt_i = 1'b1; mst_r_valid_i = 1'b1;
        #1;
        chk("rst_mst_req", mst_req_o, 1'b0);
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_r_valid", r_valid_o, 2'b00);
        chk("rst_r_rdata", r_rdata_o, 128'd0);
        cyc();
        req_i = '0; mst_gnt_i = 1'b0; mst_r_valid_i = 1'b0;
        rst = 1'b0;
        cyc();
        chk("idle_mst_req", mst_req_o, 1'b0);

        // Both requesting, immediate grants: 0, 1, 0.
        set_req(0, 64'h1000, 1'b0, 64'h0, 8'hFF);
        set_req(1, 64'h2000, 1'b0, 64'h0, 8'hF0);
        mst_gnt_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_gnt((k == 1) ? 1 : 0);
            cyc();
            mst_r_valid_i = 1'b1;
            mst_rdata_i = 64'hA0 + 64'(k);
            exp_rsp((k == 1) ? 1 : 0, 64'hA0 + 64'(k), 1'b0);
            cyc();
            mst_r_valid_i = 1'b0;
        end
        req_i = '0; mst_gnt_i = 1'b0;
        cyc();

        // Requester 1 locked; requester 0 joins but the address must not move.
        set_req(1, 64'h8000_0000, 1'b0, 64'h0, 8'hFF);
        exp_gnt(1);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) set_req(0, 64'h40, 1'b0, 64'h0, 8'hFF);
            @(negedge clk);
            chk("lock_add", mst_add_o, 64'h8000_0000);
            chk("lock_gnt", gnt_o, 2'b00);
            cyc();
        end
        mst_gnt_i = 1'b1;
        cyc();
        req_i = '0; mst_gnt_i = 1'b0;
        mst_r_valid_i = 1'b1; mst_rdata_i = 64'h77;
        exp_rsp(1, 64'h77, 1'b0);
        cyc();
        mst_r_valid_i = 1'b0;

        // Full-width write.
        set_req(0, 64'h100, 1'b1, 64'hDEAD_BEEF, 8'hFF);
        mst_gnt_i = 1'b1;
        exp_gnt(0);
        cyc();
        req_i = '0; mst_gnt_i = 1'b0;
        mst_r_valid_i = 1'b1; mst_rdata_i = 64'h0;
        exp_rsp(0, 64'h0, 1'b0);
        cyc();
        mst_r_valid_i = 1'b0;

        // Read with response after 5 wait cycles.
        set_req(0, 64'h200, 1'b0, 64'h0, 8'h0F);
        mst_gnt_i = 1'b1;
        exp_gnt(0);
        cyc();
        req_i = '0; mst_gnt_i = 1'b0;
        repeat (5) cyc();
        mst_r_valid_i = 1'b1; mst_rdata_i = 64'h1234;
        exp_rsp(0, 64'h1234, 1'b0);
        cyc();
        mst_r_valid_i = 1'b0;

        // Requester drops while locked: no grant, back to idle.
        set_req(1, 64'h300, 1'b0, 64'h0, 8'hFF);
        cyc();
        cyc();
        req_i[1] = 1'b0;
        @(negedge clk);
        chk("drop_mst_req", mst_req_o, 1'b0);
        cyc();
        set_req(0, 64'h400, 1'b0, 64'h0, 8'h3C);
        mst_gnt_i = 1'b1;
        exp_gnt(0);
        cyc();
        req_i = '0; mst_gnt_i = 1'b0;
        mst_r_valid_i = 1'b1; mst_rdata_i = 64'h99;
        exp_rsp(0, 64'h99, 1'b0);
        cyc();
        mst_r_valid_i = 1'b0;

        // Stray response in idle is ignored.
        mst_r_valid_i = 1'b1; mst_rdata_i = 64'hBAD;
        @(negedge clk);
        chk("stray_r_valid", r_valid_o, 2'b00);
        cyc();
        mst_r_valid_i = 1'b0;

`ifdef DM_BUS_ARB_TIMEOUT_EN
        // No response: error after 16 wait cycles, late response absorbed.
        set_req(0, 64'h500, 1'b0, 64'h0, 8'hFF);
        mst_gnt_i = 1'b1;
        exp_gnt(0);
        cyc();
        req_i = '0; mst_gnt_i = 1'b0;
        mst_rdata_i = 64'hFFFF;
        repeat (14) cyc();
        @(negedge clk);
        chk("to_early", r_valid_o, 2'b00);
        exp_rsp(0, 64'h0, 1'b1);
        cyc();
        @(negedge clk);
        chk("to_err", r_err_o, 2'b01);
        cyc();
        mst_r_valid_i = 1'b1; mst_rdata_i = 64'hDEAD;
        cyc();
        mst_r_valid_i = 1'b0;
        set_req(1, 64'h510, 1'b0, 64'h0, 8'hFF);
        mst_gnt_i = 1'b1;
        exp_gnt(1);
        cyc();
        req_i = '0; mst_gnt_i = 1'b0;
        mst_r_valid_i = 1'b1; mst_rdata_i = 64'h55;
        exp_rsp(1, 64'h55, 1'b0);
        cyc();
        mst_r_valid_i = 1'b0;
`endif

        // Reset while waiting for a response: abandoned, requester 0 first afterwards.
        set_req(0, 64'h600, 1'b0, 64'h0, 8'hFF);
        mst_gnt_i = 1'b1;
        exp_gnt(0);
        cyc();
        req_i = 2'b10;
        mst_r_valid_i = 1'b1; mst_rdata_i = 64'h66;
        rst = 1'b1;
        #1;
        chk("rstmid_r_valid", r_valid_o, 2'b00);
        chk("rstmid_mst_req", mst_req_o, 1'b0);
        chk("rstmid_gnt", gnt_o, 2'b00);
        cyc();
        mst_r_valid_i = 1'b0;
        rst = 1'b0;
        set_req(0, 64'h700, 1'b0, 64'h0, 8'hFF);
        set_req(1, 64'h710, 1'b0, 64'h0, 8'hFF);
        exp_gnt(0);
        cyc();
        req_i = '0; mst_gnt_i = 1'b0;
        mst_r_valid_i = 1'b1; mst_rdata_i = 64'h42;
        exp_rsp(0, 64'h42, 1'b0);
        cyc();
        mst_r_valid_i = 1'b0;

        repeat (5) cyc();
        chk("grant_queue_drained", 128'(gq.size()), 128'd0);
        chk("rsp_queue_drained", 128'(rq.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_bus_arbiter.md
DM_BUS_ARBITER -- requirements
Module: dm_bus_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/address width of all ports.
REQ-002 SHALL have parameter NR_REQ, default 2, requester count (2..4).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, response timeout (used only with DM_BUS_ARB_TIMEOUT_EN).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_i  in  NR_REQ  per-requester transfer request.
REQ-007 add_i / wdata_i  in  NR_REQ x XLEN  per-requester address / write data.
REQ-008 we_i  in  NR_REQ  per-requester write enable; be_i  in  NR_REQ x XLEN/8  byte enables.
REQ-009 gnt_o / r_valid_o / r_err_o  out  NR_REQ  per-requester grant / response valid / error.
REQ-010 r_rdata_o  out  NR_REQ x XLEN  per-requester read data.
REQ-011 mst_req_o, mst_we_o  out  1; mst_add_o, mst_wdata_o  out  XLEN; mst_be_o  out  XLEN/8  shared downstream request.
REQ-012 mst_gnt_i, mst_r_valid_i  in  1; mst_rdata_i  in  XLEN  downstream grant/response.

Function
REQ-013 SHALL implement states IDLE, LOCKED, WAIT_RSP.
REQ-014 IDLE: winner = first requesting index after last_owner (round-robin); mst_* driven combinationally from winner, zero-cycle arbitration.
REQ-015 IDLE with winner and mst_gnt_i=0 -> LOCKED, owner:=winner; LOCKED holds owner's request until mst_gnt_i regardless of other requests.
REQ-016 mst_gnt_i=1 in IDLE/LOCKED: gnt_o[owner]=1 same cycle, -> WAIT_RSP.
REQ-017 WAIT_RSP: mst_req_o=0, all gnt_o=0; mst_r_valid_i routes r_valid_o[owner]=1, r_rdata_o[owner]=mst_rdata_i same cycle, r_err_o=0, last_owner:=owner, -> IDLE.
REQ-018 One outstanding transaction; next grant no earlier than the cycle after the response.
REQ-019 Requester dropping req_i while LOCKED: SHALL return to IDLE without granting.
REQ-020 r_rdata_o of non-owners SHALL be 0; writes also get one r_valid_o response.
REQ-021 mst_r_valid_i outside WAIT_RSP (no stale pending) SHALL be ignored.

Reset
REQ-022 On rst: state IDLE, last_owner=NR_REQ-1 (requester 0 wins first), all outputs 0, counters 0.
REQ-023 Reset mid-transaction SHALL abandon it without any response.

Configuration
REQ-024 With DM_BUS_ARB_TIMEOUT_EN defined: WAIT_RSP cycle counter; at TIMEOUT_CYCLES, r_valid_o[owner]=1, r_err_o[owner]=1, r_rdata_o=0, -> IDLE, stale counter +1.
REQ-025 Stale counter (2 bits) SHALL absorb and discard the next late mst_r_valid_i per count, decrementing; grants blocked while saturated at 3.
REQ-026 Without DM_BUS_ARB_TIMEOUT_EN: no counter, r_err_o tied 0, WAIT_RSP waits indefinitely.

Structure
REQ-027 State enum and owner index width (clog2(NR_REQ)) SHALL live in shared package dm_bus_arb_pkg.
REQ-028 Round-robin selection SHALL be sub-module dm_rr_picker (req vector, last_owner -> winner, valid).

Verification
REQ-029 req_i=2'b11 simultaneous, gnt immediate: grants 0, then 1, then 0 on three back-to-back rounds.
REQ-030 Requester 1 read 0x8000_0000, mst_gnt_i delayed 3 cycles, requester 0 asserts meanwhile: mst_add_o stays 0x8000_0000 until gnt.
REQ-031 Write be=0xFF wdata=0xDEADBEEF: mst_* match, single r_valid_o[0], r_err_o=0.
REQ-032 Read response 0x1234 after 5 cycles: r_rdata_o[0]=0x1234 same cycle as mst_r_valid_i, r_rdata_o[1]=0.
REQ-033 TIMEOUT_EN, TIMEOUT_CYCLES=16, no response: r_err_o=1 after 16 cycles; late mst_r_valid_i discarded, next transaction correct.
REQ-034 rst asserted in WAIT_RSP: all outputs 0 immediately, requester 0 wins first after release.
